// File: rtl/vm_input_conditioner_pkg.sv
// Shared vending definitions: arbiter states, channel indices, credit limit
// and the fixed-priority channel picker used by the input conditioner.
package vm_input_conditioner_pkg;

    localparam int NUM_CH = 3;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_COIN   = 2'd0;
    localparam ch_idx_t CH_COFFEE = 2'd1;
    localparam ch_idx_t CH_SPRITE = 2'd2;

    localparam logic [1:0] CREDIT_MAX = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Coin beats coffee beats sprite; only meaningful when some flag is set.
    function automatic ch_idx_t pick_channel(input logic [NUM_CH-1:0] pend);
        ch_idx_t sel;
        sel = CH_SPRITE;
        if (pend[1]) sel = CH_COFFEE;
        if (pend[0]) sel = CH_COIN;
        return sel;
    endfunction

endpackage

// File: rtl/vm_debounce.sv
// One front-panel contact: 2-flop synchroniser, saturating-run debounce
// counter and a single-cycle rise strobe aligned with the debounced 0->1 edge.
module vm_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_flip;

    assign w_flip = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
    assign o_rise = w_flip && r_sync2;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser to one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (w_flip) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vm_input_conditioner.sv
// Vending front end: debounces coin/coffee/sprite contacts, queues presses as
// pending flags and serialises them into single-cycle pulses with coin reject.
module vm_input_conditioner
    import vm_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw_coin,
    input  logic       i_raw_coffee,
    input  logic       i_raw_sprite,
    input  logic [1:0] i_credit,
    output logic       o_coin,
    output logic       o_coffee,
    output logic       o_sprite,
    output logic       o_coin_reject,
    output logic       o_busy
);

    localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_pend_next;
    logic [NUM_CH-1:0] r_pend;

    arb_state_t r_state;
    arb_state_t w_next;
    ch_idx_t    r_sel;
    ch_idx_t    w_next_sel;
    logic [GW-1:0] r_gap_cnt;
    logic       w_gap_done;
    logic       w_issue_coin;

    logic r_coin;
    logic r_coffee;
    logic r_sprite;
    logic r_reject;
    logic r_busy;

    assign w_raw = {i_raw_sprite, i_raw_coffee, i_raw_coin};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        vm_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .rst   (rst),
            .i_raw (w_raw[g]),
            .o_rise(w_rise[g])
        );
    end

    // The issued channel's flag drops on the ISSUE exit edge; new rises still land.
    assign w_clr       = (r_state == ST_ISSUE) ? (NUM_CH'(1) << r_sel) : '0;
    assign w_pend_next = (r_pend & ~w_clr) | w_rise;
    assign w_gap_done  = (r_gap_cnt == GAP_LAST);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next     = r_state;
        w_next_sel = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_next     = ST_ISSUE;
                    w_next_sel = pick_channel(r_pend);
                end
            end
            ST_ISSUE: begin
                w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    if (|r_pend) begin
                        w_next     = ST_ISSUE;
                        w_next_sel = pick_channel(r_pend);
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so i_credit is taken on the
    // edge that enters ISSUE and the pulse occupies exactly the ISSUE cycle.
    assign w_issue_coin = (w_next == ST_ISSUE) && (w_next_sel == CH_COIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= CH_COIN;
            r_gap_cnt <= '0;
            r_pend    <= '0;
            r_coin    <= 1'b0;
            r_coffee  <= 1'b0;
            r_sprite  <= 1'b0;
            r_reject  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_sel    <= w_next_sel;
            r_pend   <= w_pend_next;
            r_coin   <= w_issue_coin && (i_credit != CREDIT_MAX);
            r_reject <= w_issue_coin && (i_credit == CREDIT_MAX);
            r_coffee <= (w_next == ST_ISSUE) && (w_next_sel == CH_COFFEE);
            r_sprite <= (w_next == ST_ISSUE) && (w_next_sel == CH_SPRITE);
            r_busy   <= (w_next != ST_IDLE);
            if (r_state != ST_GAP) begin
                r_gap_cnt <= '0;
            end else if (!w_gap_done) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign o_coin        = r_coin;
    assign o_coffee      = r_coffee;
    assign o_sprite      = r_sprite;
    assign o_coin_reject = r_reject;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulses (kind, cycle), negedge
// monitors pop and compare whenever either conditioner instance pulses.
module tb_vm_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_coin = 1'b0;
    logic       raw_coffee = 1'b0;
    logic       raw_sprite = 1'b0;
    logic       g0_coin = 1'b0;
    logic       g0_coffee = 1'b0;
    logic       g0_sprite = 1'b0;
    logic [1:0] credit = 2'd0;

    logic o_coin, o_coffee, o_sprite, o_coin_reject, o_busy;
    logic g0_o_coin, g0_o_coffee, g0_o_sprite, g0_o_reject, g0_o_busy;

    localparam logic [3:0] EV_COIN   = 4'b0001;
    localparam logic [3:0] EV_COFFEE = 4'b0010;
    localparam logic [3:0] EV_SPRITE = 4'b0100;
    localparam logic [3:0] EV_REJECT = 4'b1000;

    typedef struct {
        logic [3:0] outs;
        int         cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_g0[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vm_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_raw_coin   (raw_coin),
        .i_raw_coffee (raw_coffee),
        .i_raw_sprite (raw_sprite),
        .i_credit     (credit),
        .o_coin       (o_coin),
        .o_coffee     (o_coffee),
        .o_sprite     (o_sprite),
        .o_coin_reject(o_coin_reject),
        .o_busy       (o_busy)
    );

    vm_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (0)
    ) dut_g0 (
        .clk          (clk),
        .rst          (rst),
        .i_raw_coin   (g0_coin),
        .i_raw_coffee (g0_coffee),
        .i_raw_sprite (g0_sprite),
        .i_credit     (credit),
        .o_coin       (g0_o_coin),
        .o_coffee     (g0_o_coffee),
        .o_sprite     (g0_o_sprite),
        .o_coin_reject(g0_o_reject),
        .o_busy       (g0_o_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_main(input logic [3:0] outs, input int at);
        exp_t e;
        e.outs = outs;
        e.cyc  = at;
        q_main.push_back(e);
    endtask

    task automatic expect_g0(input logic [3:0] outs, input int at);
        exp_t e;
        e.outs = outs;
        e.cyc  = at;
        q_g0.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [3:0] w;
        exp_t       e;
        w = {o_coin_reject, o_sprite, o_coffee, o_coin};
        if (w != 4'b0000) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_pulse", {28'd0, w}, 32'd0);
            end else begin
                e = q_main.pop_front();
                check("main_pulse_kind", {28'd0, w}, {28'd0, e.outs});
                check("main_pulse_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] w;
        exp_t       e;
        w = {g0_o_reject, g0_o_sprite, g0_o_coffee, g0_o_coin};
        if (w != 4'b0000) begin
            if (q_g0.size() == 0) begin
                check("g0_unexpected_pulse", {28'd0, w}, 32'd0);
            end else begin
                e = q_g0.pop_front();
                check("g0_pulse_kind", {28'd0, w}, {28'd0, e.outs});
                check("g0_pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int x;

        // Reset state
        step(3);
        check("reset_outputs", {27'd0, o_busy, o_coin_reject, o_sprite, o_coffee, o_coin}, 32'd0);
        check("reset_outputs_g0", {27'd0, g0_o_busy, g0_o_reject, g0_o_sprite, g0_o_coffee, g0_o_coin}, 32'd0);
        rst = 1'b0;
        step(2);

        // Clean press: one pulse 7 cycles after the drive, none on release
        raw_coin = 1'b1;
        expect_main(EV_COIN, cyc + 7);
        step(20);
        raw_coin = 1'b0;
        step(20);

        // Bounce 1,0,1,0 then steady: one pulse timed from the steady run
        raw_coffee = 1'b1; step(1);
        raw_coffee = 1'b0; step(1);
        raw_coffee = 1'b1; step(1);
        raw_coffee = 1'b0; step(1);
        raw_coffee = 1'b1;
        expect_main(EV_COFFEE, cyc + 7);
        step(20);
        raw_coffee = 1'b0;
        step(20);

        // 3-cycle glitch: no pulse
        raw_coffee = 1'b1;
        step(3);
        raw_coffee = 1'b0;
        step(20);

        // Simultaneous press: coin, coffee, sprite 3 cycles apart, busy throughout
        raw_coin = 1'b1; raw_coffee = 1'b1; raw_sprite = 1'b1;
        x = cyc;
        expect_main(EV_COIN,   x + 7);
        expect_main(EV_COFFEE, x + 10);
        expect_main(EV_SPRITE, x + 13);
        step(6);
        check("busy_before_issue", {31'd0, o_busy}, 32'd0);
        for (int i = 7; i <= 15; i++) begin
            step(1);
            check("busy_during_burst", {31'd0, o_busy}, 32'd1);
        end
        step(1);
        check("busy_after_burst", {31'd0, o_busy}, 32'd0);
        step(4);
        raw_coin = 1'b0; raw_coffee = 1'b0; raw_sprite = 1'b0;
        step(20);

        // Full credit rejects the coin; credit 2 accepts it
        credit = 2'b11;
        step(2);
        raw_coin = 1'b1;
        expect_main(EV_REJECT, cyc + 7);
        step(20);
        raw_coin = 1'b0;
        step(20);
        credit = 2'b10;
        step(2);
        raw_coin = 1'b1;
        expect_main(EV_COIN, cyc + 7);
        step(20);
        raw_coin = 1'b0;
        step(20);

        // Reset during GAP with sprite pending and released: sprite discarded
        raw_coin = 1'b1; raw_sprite = 1'b1;
        x = cyc;
        expect_main(EV_COIN, x + 7);
        step(6);
        raw_coin = 1'b0; raw_sprite = 1'b0;
        step(2);
        check("busy_in_gap", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        step(1);
        check("reset_mid_gap", {27'd0, o_busy, o_coin_reject, o_sprite, o_coffee, o_coin}, 32'd0);
        step(1);
        rst = 1'b0;
        step(30);

        // Reset during GAP with sprite still held: one sprite after reset
        raw_coin = 1'b1; raw_sprite = 1'b1;
        x = cyc;
        expect_main(EV_COIN, x + 7);
        step(6);
        raw_coin = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        check("reset_held_outputs", {27'd0, o_busy, o_coin_reject, o_sprite, o_coffee, o_coin}, 32'd0);
        step(1);
        rst = 1'b0;
        expect_main(EV_SPRITE, cyc + 7);
        step(15);
        raw_sprite = 1'b0;
        step(20);

        // GAP_CYCLES=0: two events, one idle cycle between pulses
        g0_coin = 1'b1; g0_coffee = 1'b1;
        x = cyc;
        expect_g0(EV_COIN,   x + 7);
        expect_g0(EV_COFFEE, x + 9);
        step(7);
        check("g0_busy_issue1", {31'd0, g0_o_busy}, 32'd1);
        step(1);
        check("g0_busy_between", {31'd0, g0_o_busy}, 32'd0);
        step(1);
        check("g0_busy_issue2", {31'd0, g0_o_busy}, 32'd1);
        step(15);
        g0_coin = 1'b0; g0_coffee = 1'b0;
        step(20);

        check("main_missing_pulses", q_main.size(), 32'd0);
        check("g0_missing_pulses", q_g0.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
